// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the 4-requester round-robin output mux.
// Pure declarations; no timing or flow-control behaviour of its own.
package mux_arb_pkg;

  localparam int N_REQ = 4;

  typedef logic [1:0] src_t;

  // Rotating-pointer advance; the 2-bit type gives the 3->0 wrap for free.
  function automatic src_t rr_next(input src_t s);
    return s + 2'd1;
  endfunction

endpackage

// File: rtl/rr_pick_4.sv
// Combinational rotating-priority picker: first set req bit at ptr, ptr+1, ... (mod 4).
// Zero latency; no flow control, gnt is meaningful only while gnt_valid is high.
module rr_pick_4
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  src_t             ptr,
  output logic             gnt_valid,
  output src_t             gnt
);

  src_t idx;

  // Scan from the farthest offset down so the nearest requester to ptr wins.
  always_comb begin
    gnt_valid = |req;
    gnt       = ptr;
    idx       = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = ptr + src_t'(k);
      if (req[idx]) gnt = idx;
    end
  end

endmodule

// File: rtl/rr_mux_arbiter_4.sv
// Round-robin 4:1 arbiter into one registered output beat, optional BURST beats per winner.
// In-handshake to out_valid is 1 clk; a stalled output (out_valid & ~out_ready) holds in_ready at 0.
module rr_mux_arbiter_4
  import mux_arb_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int BURST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] in_valid,
  input  logic [WIDTH-1:0] in_data0,
  input  logic [WIDTH-1:0] in_data1,
  input  logic [WIDTH-1:0] in_data2,
  input  logic [WIDTH-1:0] in_data3,
  output logic [N_REQ-1:0] in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output src_t             out_src,
  input  logic             out_ready
);

  localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST - 1);

  src_t             ptr;
  src_t             owner;
  logic             burst_open;
  logic [CW-1:0]    burst_cnt;

  logic             pick_valid;
  src_t             pick_src;
  logic             load;
  logic             keep;
  src_t             winner;
  logic [CW-1:0]    cnt_nxt;
  logic             burst_end;
  logic [WIDTH-1:0] sel_data;
  logic [N_REQ-1:0] onehot;

  rr_pick_4 u_pick (
    .req       (in_valid),
    .ptr       (ptr),
    .gnt_valid (pick_valid),
    .gnt       (pick_src)
  );

  // burst_open is only ever set when BURST > 1, because a fresh burst of one beat ends at once.
  always_comb begin
    load      = (~out_valid | out_ready) & pick_valid;
    keep      = burst_open & in_valid[owner] & (burst_cnt < CNT_LAST);
    winner    = keep ? owner : pick_src;
    cnt_nxt   = keep ? burst_cnt + 1'b1 : '0;
    burst_end = (cnt_nxt == CNT_LAST);
    onehot    = '0;
    onehot[winner] = 1'b1;
    in_ready  = (load & rst_n) ? onehot : '0;
  end

  always_comb begin
    sel_data = in_data0;
    case (winner)
      2'd0:    sel_data = in_data0;
      2'd1:    sel_data = in_data1;
      2'd2:    sel_data = in_data2;
      default: sel_data = in_data3;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_src    <= '0;
      ptr        <= '0;
      owner      <= '0;
      burst_open <= 1'b0;
      burst_cnt  <= '0;
    end else if (load) begin
      out_valid  <= 1'b1;
      out_data   <= sel_data;
      out_src    <= winner;
      owner      <= winner;
      burst_cnt  <= cnt_nxt;
      burst_open <= ~burst_end;
      // Pointer moves past the winner when a burst starts; on its last beat that is the same value.
      if (!keep || burst_end) ptr <= rr_next(winner);
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule
